// File: rtl/cpci_intr_pkg.sv
// cpci_intr_pkg: status bit positions, default mask and holdoff FSM encoding
// shared by the CPCI interrupt controller and its holdoff sub-module.
// Register word addresses come from the CPCI register defines; fallbacks are
// provided here so the block also elaborates standalone.
`ifndef CPCI_INTERRUPT_STATUS
`define CPCI_INTERRUPT_STATUS 22'h000040
`endif
`ifndef CPCI_INTERRUPT_MASK
`define CPCI_INTERRUPT_MASK 22'h000041
`endif

package cpci_intr_pkg;

    localparam int INTR_INGRESS_DONE    = 31;
    localparam int INTR_EGRESS_DONE     = 30;
    localparam int INTR_PHY             = 29;
    localparam int INTR_Q_STATUS        = 9;
    localparam int INTR_PKT_AVAIL       = 8;
    localparam int INTR_CNET_ERR        = 5;
    localparam int INTR_CNET_RD_TIMEOUT = 4;
    localparam int INTR_CNET_PROG_ERR   = 3;
    localparam int INTR_DMA_TIMEOUT     = 2;
    localparam int INTR_DMA_ERR         = 1;
    localparam int INTR_DMA_FATAL       = 0;

    // Every defined status bit; also the mask value out of reset.
    localparam logic [31:0] DEF_MASK = 32'hE000_033F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERTED = 2'd1,
        HOLDOFF  = 2'd2
    } holdoff_state_e;

endpackage

// File: rtl/cpci_intr_holdoff.sv
// cpci_intr_holdoff: interrupt coalescing. Once intr_n has been released it
// stays released for HOLDOFF_CYCLES cycles; anything pending meanwhile is
// presented after the holdoff expires. Used only with CPCI_INTR_COALESCE_EN.
module cpci_intr_holdoff
    import cpci_intr_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic pending_i,
    output logic intr_n_o
);

    localparam int CW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;

    holdoff_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           intr_n_q;

    // State, holdoff counter and a registered pad output (no decode glitches).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            intr_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            intr_n_q <= (state_d != ASSERTED);
        end
    end

    // Next state: assert on pending, release into a timed holdoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:     if (pending_i) state_d = ASSERTED;
            ASSERTED: if (!pending_i) begin
                state_d = HOLDOFF;
                cnt_d   = CW'(HOLDOFF_CYCLES - 1);
            end
            HOLDOFF:  if (cnt_q == '0) state_d = IDLE;
                      else             cnt_d   = cnt_q - 1'b1;
            default:  state_d = IDLE;
        endcase
    end

    assign intr_n_o = intr_n_q;

endmodule

// File: rtl/cpci_intr_ctrl.sv
// cpci_intr_ctrl: INTERRUPT_STATUS (read-to-clear) and INTERRUPT_MASK
// registers, driving the PCI INTA# line. Define CPCI_INTR_COALESCE_EN to add a
// minimum deasserted time (HOLDOFF_CYCLES) between interrupts.
module cpci_intr_ctrl
    import cpci_intr_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 22,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR    = ADDR_WIDTH'(`CPCI_INTERRUPT_STATUS),
    parameter logic [ADDR_WIDTH-1:0] MASK_ADDR      = ADDR_WIDTH'(`CPCI_INTERRUPT_MASK),
    parameter int                    HOLDOFF_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ev_ingress_done,
    input  logic                  ev_egress_done,
    input  logic                  ev_phy,
    input  logic                  ev_q_status,
    input  logic                  ev_cnet_err,
    input  logic                  ev_cnet_rd_timeout,
    input  logic                  ev_cnet_prog_err,
    input  logic                  ev_dma_timeout,
    input  logic                  ev_dma_err,
    input  logic                  ev_dma_fatal,
    input  logic                  pkt_avail,
    input  logic                  reg_rd_req,
    input  logic                  reg_wr_req,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_wr_data,
    output logic [31:0]           reg_rd_data,
    output logic                  reg_rd_vld,
    output logic                  intr_n
);

    if (HOLDOFF_CYCLES < 2) begin : g_bad_holdoff
        $error("cpci_intr_ctrl: HOLDOFF_CYCLES must be at least 2");
    end

    logic [31:0] latched_q, latched_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic        pkt_q;
    logic [31:0] ev_set, status_view;
    logic        pending, rd_ok;

    // Collect event pulses; pkt_avail latches only on its rising edge.
    always_comb begin
        ev_set                       = '0;
        ev_set[INTR_INGRESS_DONE]    = ev_ingress_done;
        ev_set[INTR_EGRESS_DONE]     = ev_egress_done;
        ev_set[INTR_PHY]             = ev_phy;
        ev_set[INTR_Q_STATUS]        = ev_q_status;
        ev_set[INTR_PKT_AVAIL]       = pkt_avail & ~pkt_q;
        ev_set[INTR_CNET_ERR]        = ev_cnet_err;
        ev_set[INTR_CNET_RD_TIMEOUT] = ev_cnet_rd_timeout;
        ev_set[INTR_CNET_PROG_ERR]   = ev_cnet_prog_err;
        ev_set[INTR_DMA_TIMEOUT]     = ev_dma_timeout;
        ev_set[INTR_DMA_ERR]         = ev_dma_err;
        ev_set[INTR_DMA_FATAL]       = ev_dma_fatal;
    end

    assign status_view = (latched_q | (32'(pkt_avail) << INTR_PKT_AVAIL)) & DEF_MASK;
    assign pending     = |(status_view & ~mask_q);
    // A write in the same cycle as a read takes precedence; the read is dropped.
    assign rd_ok       = reg_rd_req & ~reg_wr_req;

    // Register access decode; new events are OR'd in last so they survive a clear.
    always_comb begin
        latched_d = latched_q;
        mask_d    = mask_q;
        rd_data_d = '0;
        rd_vld_d  = 1'b0;
        if (reg_wr_req) begin
            if (reg_addr == MASK_ADDR) mask_d = reg_wr_data & DEF_MASK;
        end else if (rd_ok) begin
            rd_vld_d = 1'b1;
            if (reg_addr == STATUS_ADDR) begin
                rd_data_d = status_view;
                latched_d = latched_q & ~status_view;
            end else if (reg_addr == MASK_ADDR) begin
                rd_data_d = mask_q;
            end
        end
        latched_d = (latched_d | ev_set) & DEF_MASK;
    end

    // Register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            latched_q <= '0;
            mask_q    <= DEF_MASK;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            pkt_q     <= 1'b0;
        end else begin
            latched_q <= latched_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            pkt_q     <= pkt_avail;
        end
    end

    assign reg_rd_data = rd_data_q;
    assign reg_rd_vld  = rd_vld_q;

`ifdef CPCI_INTR_COALESCE_EN
    cpci_intr_holdoff #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk       (clk),
        .reset     (reset),
        .pending_i (pending),
        .intr_n_o  (intr_n)
    );
`else
    logic intr_n_q;

    // Pad output follows pending through one register stage.
    always_ff @(posedge clk) begin
        if (reset) intr_n_q <= 1'b1;
        else       intr_n_q <= ~pending;
    end

    assign intr_n = intr_n_q;
`endif

endmodule
